controller: RTL and testbench

Multi-cycle instruction sequencer for the 10-bit datapath. It latches a 10-bit instruction on an Exec request and steps through up to three execution steps (T1–T3). In each step it drives the register-file controls (ENW/WRA, ENR0/RDA0, ENR1/RDA1), the ALU controls and the bus-source enables. It sits directly upstream of the register file and the ALU.

---
 rtl/controller.sv | 207 ++++++++++++++++++++
 tb/tb_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
`default_nettype none
// ============================================================================
// Module      : controller
// Description : Multi-cycle instruction sequencer for the 10-bit datapath.
//               An instruction is latched on a rising Exec. The sequencer then
//               steps through T1..T3. In each step it drives the register-file
//               controls, the ALU controls and the bus-source enables. State
//               changes occur on the falling edge of CLKb.
//
// Ports       : CLKb    - debounced clock (falling-edge active)
//               Rst     - asynchronous active-high reset
//               Exec    - execute request (rising transition starts)
//               INST    - instruction [9:6] op, [5:4] Rx, [3:2] Ry, [3:0] imm
//               PeekEn  - peek read enable     -> ENR1
//               PeekA   - peek read address    -> RDA1
//               ENW/WRA - register-file write enable / address
//               ENR0/RDA0 - register-file bus read enable / address
//               Ain/Gin/Gout/FN - ALU operand latch, result latch, result
//                         drive, function
//               Extrn/IMMout - external data / immediate bus drivers
//               Done    - final step of the current instruction
//               Step    - current step (0 = idle, 1..3 = T1..T3)
//
// Build macro : CTRL_IMM_EN - when defined, ADDI (1001) and SUBI (1010) are
//               decoded and IMMout is live. Otherwise those opcodes behave
//               as reserved and IMMout is constant 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module controller (
    input  logic       CLKb,
    input  logic       Rst,
    input  logic       Exec,
    input  logic [9:0] INST,
    input  logic       PeekEn,
    input  logic [1:0] PeekA,
    output logic       ENW,
    output logic [1:0] WRA,
    output logic       ENR0,
    output logic [1:0] RDA0,
    output logic       ENR1,
    output logic [1:0] RDA1,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic [3:0] FN,
    output logic       Extrn,
    output logic       IMMout,
    output logic       Done,
    output logic [1:0] Step
);

    typedef enum logic [1:0] {
        ST_T0 = 2'd0,
        ST_T1 = 2'd1,
        ST_T2 = 2'd2,
        ST_T3 = 2'd3
    } step_t;

    step_t       r_step;
    step_t       w_step_nxt;
    logic [9:0]  r_ir;
    logic        r_exec_q;

    logic [3:0]  w_op;
    logic [1:0]  w_rx;
    logic [1:0]  w_ry;
    logic        w_start;
    logic        w_is_load;
    logic        w_is_copy;
    logic        w_is_bin;
    logic        w_is_un;
    logic        w_is_imm;
    logic        w_done;

    // The immediate itself reaches the bus through the datapath, so the low
    // IR bits are held here but not decoded by the sequencer.
    logic        w_unused_ir;
    assign w_unused_ir = ^r_ir[1:0];

    assign w_op = r_ir[9:6];
    assign w_rx = r_ir[5:4];
    assign w_ry = r_ir[3:2];

    // A start needs a low->high Exec transition seen while idle. Rises during
    // an instruction are dropped, not queued.
    assign w_start = Exec && !r_exec_q && (r_step == ST_T0);

    assign w_is_load = (w_op == 4'b0000);
    assign w_is_copy = (w_op == 4'b0001);
    assign w_is_bin  = (w_op == 4'b0010) || (w_op == 4'b0011) ||
                       (w_op == 4'b0110) || (w_op == 4'b0111) ||
                       (w_op == 4'b1000);
    assign w_is_un   = (w_op == 4'b0100) || (w_op == 4'b0101);
`ifdef CTRL_IMM_EN
    assign w_is_imm  = (w_op == 4'b1001) || (w_op == 4'b1010);
`else
    assign w_is_imm  = 1'b0;
`endif

    // Peek port is independent of the sequencer.
    assign ENR1 = PeekEn;
    assign RDA1 = PeekA;
    assign Step = r_step;
    assign Done = w_done;

    always_ff @(negedge CLKb or posedge Rst) begin
        if (Rst) begin
            r_step   <= ST_T0;
            r_ir     <= 10'd0;
            r_exec_q <= 1'b0;
        end else begin
            r_step   <= w_step_nxt;
            r_exec_q <= Exec;
            if (w_start) begin
                r_ir <= INST;
            end
        end
    end

    // Step decode: every control is a pure function of Step and IR, so an
    // asynchronous reset of Step drops all drivers immediately.
    always_comb begin
        ENW    = 1'b0;
        WRA    = 2'd0;
        ENR0   = 1'b0;
        RDA0   = 2'd0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        FN     = 4'd0;
        Extrn  = 1'b0;
        IMMout = 1'b0;
        w_done = 1'b0;

        case (r_step)
            ST_T1: begin
                if (w_is_load) begin
                    Extrn  = 1'b1;
                    ENW    = 1'b1;
                    WRA    = w_rx;
                    w_done = 1'b1;
                end else if (w_is_copy) begin
                    ENR0   = 1'b1;
                    RDA0   = w_ry;
                    ENW    = 1'b1;
                    WRA    = w_rx;
                    w_done = 1'b1;
                end else if (w_is_bin || w_is_imm) begin
                    ENR0   = 1'b1;
                    RDA0   = w_rx;
                    Ain    = 1'b1;
                end else if (w_is_un) begin
                    ENR0   = 1'b1;
                    RDA0   = w_ry;
                    Gin    = 1'b1;
                    FN     = w_op;
                end else begin
                    // Reserved opcode: single step, nothing driven.
                    w_done = 1'b1;
                end
            end
            ST_T2: begin
                if (w_is_bin) begin
                    ENR0   = 1'b1;
                    RDA0   = w_ry;
                    Gin    = 1'b1;
                    FN     = w_op;
                end else if (w_is_imm) begin
                    IMMout = 1'b1;
                    Gin    = 1'b1;
                    FN     = w_op;
                end else if (w_is_un) begin
                    Gout   = 1'b1;
                    ENW    = 1'b1;
                    WRA    = w_rx;
                    w_done = 1'b1;
                end else begin
                    // Unreachable for valid sequences; force a return to idle.
                    w_done = 1'b1;
                end
            end
            ST_T3: begin
                if (w_is_bin || w_is_imm) begin
                    Gout   = 1'b1;
                    ENW    = 1'b1;
                    WRA    = w_rx;
                end
                w_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        w_step_nxt = r_step;
        case (r_step)
            ST_T0:   w_step_nxt = w_start ? ST_T1 : ST_T0;
            ST_T1:   w_step_nxt = w_done  ? ST_T0 : ST_T2;
            ST_T2:   w_step_nxt = w_done  ? ST_T0 : ST_T3;
            default: w_step_nxt = ST_T0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_controller
// Description : Directed, table-driven bench for the controller sequencer.
//               A vector table drives the common sequences, and hand-written
//               sequences cover asynchronous reset, Exec held high and
//               Exec held high across reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controller;

    logic       CLKb;
    logic       Rst;
    logic       Exec;
    logic [9:0] INST;
    logic       PeekEn;
    logic [1:0] PeekA;
    logic       ENW;
    logic [1:0] WRA;
    logic       ENR0;
    logic [1:0] RDA0;
    logic       ENR1;
    logic [1:0] RDA1;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic [3:0] FN;
    logic       Extrn;
    logic       IMMout;
    logic       Done;
    logic [1:0] Step;

    int n_checks = 0;
    int n_fail   = 0;

    controller dut (
        .CLKb   (CLKb),
        .Rst    (Rst),
        .Exec   (Exec),
        .INST   (INST),
        .PeekEn (PeekEn),
        .PeekA  (PeekA),
        .ENW    (ENW),
        .WRA    (WRA),
        .ENR0   (ENR0),
        .RDA0   (RDA0),
        .ENR1   (ENR1),
        .RDA1   (RDA1),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .FN     (FN),
        .Extrn  (Extrn),
        .IMMout (IMMout),
        .Done   (Done),
        .Step   (Step)
    );

    initial CLKb = 1'b1;
    always #5 CLKb = ~CLKb;

    typedef struct {
        logic        exec;
        logic [9:0]  inst;
        logic        pen;
        logic [1:0]  pa;
        logic [20:0] exp;
    } vec_t;

    vec_t tv[$];

    // Expected-output packer:
    // {ENW,WRA,ENR0,RDA0,ENR1,RDA1,Ain,Gin,Gout,FN,Extrn,IMMout,Done,Step}
    function automatic logic [20:0] E(
        input logic [1:0] step, input logic done, input logic enw,
        input logic [1:0] wra, input logic enr0, input logic [1:0] rda0,
        input logic ain, input logic gin, input logic gout,
        input logic [3:0] fn, input logic extrn, input logic imm,
        input logic enr1, input logic [1:0] rda1);
        return {enw, wra, enr0, rda0, enr1, rda1, ain, gin, gout, fn,
                extrn, imm, done, step};
    endfunction

    function automatic logic [20:0] actual();
        return {ENW, WRA, ENR0, RDA0, ENR1, RDA1, Ain, Gin, Gout, FN,
                Extrn, IMMout, Done, Step};
    endfunction

    task automatic add(input logic exec, input logic [9:0] inst,
                       input logic pen, input logic [1:0] pa,
                       input logic [20:0] exp);
        vec_t v;
        v.exec = exec; v.inst = inst; v.pen = pen; v.pa = pa; v.exp = exp;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [20:0] got,
                         input logic [20:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (time %0t)", name, got, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic [3:0] got,
                          input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (time %0t)", name, got, exp, $time);
        end
    endtask

    // One sequencer step: inputs are set now (away from the falling edge),
    // the falling edge acts, outputs are sampled after the next rising edge.
    task automatic cycle();
        @(negedge CLKb);
        @(posedge CLKb);
        #1;
    endtask

    localparam logic [20:0] c_IDLE = 21'd0;

    initial begin
        int n_done;

        Rst = 1'b1; Exec = 1'b0; INST = 10'd0; PeekEn = 1'b1; PeekA = 2'd2;
        @(posedge CLKb); #1;
        check("reset_state", actual(), E(0,0,0,0,0,0,0,0,0,0,0,0,1,2));
        PeekEn = 1'b0; PeekA = 2'd0;
        Rst = 1'b0;

        // ---------------- vector table ----------------
        add(0, 10'b0000_00_00_00, 0, 0, c_IDLE);
        add(1, 10'b0000_10_00_00, 0, 0, E(1,1,1,2,0,0,0,0,0,0,1,0,0,0)); // LOAD
        add(0, 10'b0000_10_00_00, 0, 0, c_IDLE);
        add(1, 10'b0010_01_11_00, 0, 0, E(1,0,0,0,1,1,1,0,0,0,0,0,0,0)); // ADD T1
        add(1, 10'b0010_01_11_00, 0, 0, E(2,0,0,0,1,3,0,1,0,2,0,0,0,0)); // T2
        add(1, 10'b0010_01_11_00, 0, 0, E(3,1,1,1,0,0,0,0,1,0,0,0,0,0)); // T3
        add(1, 10'b0010_01_11_00, 0, 0, c_IDLE);                          // held: no restart
        add(0, 10'b0000_00_00_00, 0, 0, c_IDLE);
        add(1, 10'b0001_10_01_00, 0, 0, E(1,1,1,2,1,1,0,0,0,0,0,0,0,0)); // COPY
        add(0, 10'b0000_00_00_00, 0, 0, c_IDLE);
        add(1, 10'b0100_11_10_00, 0, 0, E(1,0,0,0,1,2,0,1,0,4,0,0,0,0)); // INV T1
        add(0, 10'b0000_00_00_00, 0, 0, E(2,1,1,3,0,0,0,0,1,0,0,0,0,0)); // INV T2
        add(0, 10'b0000_00_00_00, 0, 0, c_IDLE);
        add(1, 10'b1100_01_01_01, 0, 0, E(1,1,0,0,0,0,0,0,0,0,0,0,0,0)); // reserved
        add(0, 10'b0000_00_00_00, 0, 0, c_IDLE);
        add(1, 10'b1000_10_01_00, 0, 0, E(1,0,0,0,1,2,1,0,0,0,0,0,0,0)); // XOR T1
        add(0, 10'b0000_00_00_00, 0, 0, E(2,0,0,0,1,1,0,1,0,8,0,0,0,0));
        add(0, 10'b0000_00_00_00, 0, 0, E(3,1,1,2,0,0,0,0,1,0,0,0,0,0));
        add(0, 10'b0000_00_00_00, 0, 0, c_IDLE);
        // SUB with peek active; second Exec rise in T2 and INST change ignored
        add(1, 10'b0011_01_10_00, 1, 2, E(1,0,0,0,1,1,1,0,0,0,0,0,1,2));
        add(0, 10'b0011_01_10_00, 1, 2, E(2,0,0,0,1,2,0,1,0,3,0,0,1,2));
        add(1, 10'b0000_00_00_00, 1, 2, E(3,1,1,1,0,0,0,0,1,0,0,0,1,2));
        add(1, 10'b0000_00_00_00, 0, 2, E(0,0,0,0,0,0,0,0,0,0,0,0,0,2));
        add(0, 10'b0000_00_00_00, 0, 0, c_IDLE);
`ifdef CTRL_IMM_EN
        add(1, 10'b1001_11_0101, 0, 0, E(1,0,0,0,1,3,1,0,0,0,0,0,0,0)); // ADDI
        add(0, 10'b0000_00_00_00, 0, 0, E(2,0,0,0,0,0,0,1,0,9,0,1,0,0));
        add(0, 10'b0000_00_00_00, 0, 0, E(3,1,1,3,0,0,0,0,1,0,0,0,0,0));
`else
        add(1, 10'b1001_11_0101, 0, 0, E(1,1,0,0,0,0,0,0,0,0,0,0,0,0)); // ADDI as reserved
        add(0, 10'b0000_00_00_00, 0, 0, c_IDLE);
        add(0, 10'b0000_00_00_00, 0, 0, c_IDLE);
`endif
        add(0, 10'b0000_00_00_00, 0, 0, c_IDLE);

        foreach (tv[i]) begin
            Exec = tv[i].exec; INST = tv[i].inst;
            PeekEn = tv[i].pen; PeekA = tv[i].pa;
            cycle();
            check($sformatf("vec%0d", i), actual(), tv[i].exp);
        end

        // ---------------- Exec held high after COPY ----------------
        INST = 10'b0001_00_01_00; Exec = 1'b1;
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (Done) n_done++;
        end
        check1("held_exec_done_count", n_done[3:0], 4'd1);
        check1("held_exec_step", {2'b00, Step}, 4'd0);
        Exec = 1'b0;
        cycle();

        // ---------------- reset in T2 of ADD ----------------
        INST = 10'b0010_01_11_00; Exec = 1'b1;
        cycle();
        cycle();
        check1("rst_pre_step", {2'b00, Step}, 4'd2);
        Rst = 1'b1;
        #1;
        check("rst_async", actual(), c_IDLE);
        cycle();
        check("rst_held_edge", actual(), c_IDLE);
        // Exec still high across release: Exec_q was cleared, so it starts
        Rst = 1'b0;
        cycle();
        check("start_after_release", actual(), E(1,0,0,0,1,1,1,0,0,0,0,0,0,0));
        Exec = 1'b0;
        cycle();
        cycle();
        cycle();
        check("idle_after_release_add", actual(), c_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the directed run is short; anything longer is a hang.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
